proc_param: RTL
===============

// Module: proc_param
// PURPOSE
//  Parametrised multi-cycle processor core; next generation of the 16-bit/8-register proc.
//  Width and register count are generic. Explicit FSM with Run/Done handshake.
//  Memory ld/st go through ADDR/DOUT/W; read data returns on DIN.
//  Illegal opcodes are flagged on Err. Sits under the top-level with the memory and PC/IO glue.
// PARAMETERS
//  DW     16  data/bus width in bits; must be >= IW and >= 8
//  NREGS  8   number of GPRs R0..R(NREGS-1); power of 2, range 2..16
//  derived: RB = $clog2(NREGS); IW = 4 + 2*RB (instruction width); SB = $clog2(DW) (shift bits)
// PORTS
//  Clock     in   1   rising-edge clock
//  Reset     in   1   asynchronous, active-high; clears all state
//  Run       in   1   start request, sampled only in S_IDLE
//  DIN       in   DW  instruction (low IW bits), mvi immediate, or ld read data
//  Done      out  1   high during the last cycle of each instruction
//  Err       out  1   high with Done when the opcode is illegal
//  BusWires  out  DW  internal bus value this cycle (debug/observe)
//  ADDR      out  DW  memory address register
//  DOUT      out  DW  memory write data register
//  W         out  1   memory write strobe, one cycle
// BEHAVIOUR
//  Reset: FSM -> S_IDLE. Rx, A, G, IR, ADDR and DOUT clear to 0. Done, Err, W and BusWires read 0.
//  IR = {op[3:0], X[RB-1:0], Y[RB-1:0]}.
//  Opcodes: 0 ld, 1 st, 2 mvnz, 3 mv, 4 mvi, 5 add, 6 sub, 7 or, 8 slt, 9 sll, A srl; B-F illegal.
//  Control outputs (Done, Err, W, bus select, register enables) are combinational from state and IR.
//  Storage updates on Clock rising edge.
//  S_IDLE: if Run, IR <= DIN[IW-1:0] and go to S_T1. Else hold.
//  S_T1: action depends on the opcode.
//   - mv: Rx <= Ry; Done; go to S_IDLE.
//   - mvnz: Rx <= Ry only if G != 0; Done; go to S_IDLE.
//   - mvi: Rx <= DIN (immediate is valid this cycle); Done; go to S_IDLE.
//   - ALU ops: A <= Rx; go to S_T2.
//   - ld and st: ADDR <= Ry; go to S_T2.
//   - illegal: Done and Err, no register write; go to S_IDLE.
//  S_T2: action depends on the opcode.
//   - ALU ops: G <= f(A, Ry); go to S_T3.
//   - ld: wait state for the synchronous memory; go to S_T3.
//   - st: DOUT <= Rx; W = 1 this cycle; Done; go to S_IDLE.
//  S_T3: ALU ops: Rx <= G. ld: Rx <= DIN. Done in both cases; go to S_IDLE.
//  Latency: mv/mvnz/mvi/illegal take 2 cycles, st 3, ALU and ld 4 (each including S_IDLE fetch).
//  Arithmetic: add and sub are modulo 2^DW. or is bitwise.
//   slt: G = 1 if signed A < signed Ry, else 0.
//   sll/srl: logical shift of A by Ry[SB-1:0]; shifting by DW-1 is legal.
//  Bus priority, one source at a time: DIN, G, then Rsel. BusWires = 0 when nothing drives it.
//  Run is ignored outside S_IDLE. Dropping Run mid-instruction does not abort it.
//  Run held high gives back-to-back instructions: the next fetch is the S_IDLE cycle after Done.
//  X == Y is legal. "add R1,R1" doubles R1.
//  Reset asserted mid-instruction aborts immediately; no partial write or W pulse completes.
// CONFIGURATION
//  PROC_SHIFT_EN defined: sll/srl implemented as above.
//  PROC_SHIFT_EN undefined: opcodes 9 and A decode as illegal (2 cycles, Done with Err).
//   No shifter is synthesised.
// STRUCTURE
//  Package proc_pkg holds:
//   - opcode localparams OP_LD..OP_SRL;
//   - the state enum S_IDLE, S_T1, S_T2, S_T3;
//   - the ALU function code typedef alu_op_t.
//  Sub-module proc_alu (DW parameter) takes alu_op_t, a and b, and returns the result.
//  Everything else (register file array, FSM, bus mux) stays inline.
// TESTING
//  All with DW=16, NREGS=8. Build and run once with PROC_SHIFT_EN and once without.
//  1. mvi R1,5 then mvi R2,3 then add R1,R2: R1 == 8.
//     Done high in exactly cycle 2, 4 and 8 counted from the first Run.
//  2. mvi R3,0x8000; mvi R4,1; slt R3,R4 gives R3 == 1. Then sub R4,R4 gives R4 == 0.
//  3. mvi R5,0x0001; mvi R6,15; sll R5,R6 gives R5 == 0x8000 with PROC_SHIFT_EN.
//     Without the macro, R5 is unchanged and Err is pulsed.
//  4. st R1,R2 with R1=0xBEEF, R2=0x20: ADDR == 0x20, DOUT == 0xBEEF, W high one cycle.
//     Then ld R7,R2 with DIN=0x1234 in S_T3: R7 == 0x1234.
//  5. Executing a sub that leaves G == 0, then mvnz R0,R1, leaves R0 unchanged.
//     After add produces G != 0, mvnz copies R1 into R0.
//  6. Assert Reset during S_T2 of add: next cycle Done = 0, W = 0 and all registers read 0.
//     The following Run fetches normally.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multi-cycle processor: opcodes, FSM states
// and ALU function codes.
package proc_pkg;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_MVNZ = 4'h2;
  localparam logic [3:0] OP_MV   = 4'h3;
  localparam logic [3:0] OP_MVI  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

  // Only meaningful for opcodes the core already classified as ALU instructions.
  function automatic alu_op_t alu_decode(input logic [3:0] op);
    alu_op_t f;
    case (op)
      OP_SUB:  f = ALU_SUB;
      OP_OR:   f = ALU_OR;
      OP_SLT:  f = ALU_SLT;
      OP_SLL:  f = ALU_SLL;
      OP_SRL:  f = ALU_SRL;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/proc_param_if.sv
// Handshake and memory-side signals of the processor core. The core takes the master
// modport; the surrounding system (memory, PC/IO glue) takes the slave modport.
interface proc_param_if #(parameter int DW = 16);
  logic          Run;
  logic [DW-1:0] DIN;
  logic          Done;
  logic          Err;
  logic [DW-1:0] BusWires;
  logic [DW-1:0] ADDR;
  logic [DW-1:0] DOUT;
  logic          W;

  modport master (input Run, DIN, output Done, Err, BusWires, ADDR, DOUT, W);
  modport slave  (output Run, DIN, input Done, Err, BusWires, ADDR, DOUT, W);
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU of the processor. The shifter exists only when PROC_SHIFT_EN is
// defined; otherwise shift codes produce 0 and are never selected by the core.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DW = 16
) (
  input  alu_op_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

`ifdef PROC_SHIFT_EN
  localparam int SB = $clog2(DW);
  logic [SB-1:0] shamt;
  assign shamt = b[SB-1:0];
`endif

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef PROC_SHIFT_EN
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = a >> shamt;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/proc_param.sv
// Parametrised multi-cycle processor core with Run/Done handshake and ld/st memory port.
// Define PROC_SHIFT_EN to implement sll/srl; otherwise those opcodes decode as illegal.
module proc_param
  import proc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 8
) (
  input logic         Clock,
  input logic         Reset,
  proc_param_if.master bus
);

  localparam int RB = $clog2(NREGS);
  localparam int IW = 4 + 2 * RB;

  state_t        state_reg, state_next;
  logic [IW-1:0] ir_reg;
  logic [DW-1:0] r_reg [NREGS];
  logic [DW-1:0] a_reg, g_reg, addr_reg, dout_reg;
  logic [DW-1:0] alu_y, bus_val;
  logic [3:0]    op;
  logic [RB-1:0] rx, ry, sel_idx;
  logic          alu_cmd, sel_din, sel_g, sel_r;
  logic          ir_wr, rx_wr, a_wr, g_wr, addr_wr, dout_wr;
  logic          done, err, w;
  alu_op_t       alu_fn;

  assign op = ir_reg[IW-1 -: 4];
  assign rx = ir_reg[2*RB-1 -: RB];
  assign ry = ir_reg[RB-1:0];

`ifdef PROC_SHIFT_EN
  assign alu_cmd = (op >= OP_ADD) && (op <= OP_SRL);
`else
  assign alu_cmd = (op >= OP_ADD) && (op <= OP_SLT);
`endif

  assign alu_fn = alu_decode(op);

  proc_alu #(.DW(DW)) u_alu (
    .op (alu_fn),
    .a  (a_reg),
    .b  (bus_val),
    .y  (alu_y)
  );

  // Single-source bus; priority only matters if decode ever selects two at once.
  always_comb begin
    bus_val = '0;
    if (sel_din)    bus_val = bus.DIN;
    else if (sel_g) bus_val = g_reg;
    else if (sel_r) bus_val = r_reg[sel_idx];
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    err        = 1'b0;
    w          = 1'b0;
    sel_din    = 1'b0;
    sel_g      = 1'b0;
    sel_r      = 1'b0;
    sel_idx    = ry;
    ir_wr      = 1'b0;
    rx_wr      = 1'b0;
    a_wr       = 1'b0;
    g_wr       = 1'b0;
    addr_wr    = 1'b0;
    dout_wr    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.Run) begin
          ir_wr      = 1'b1;
          state_next = S_T1;
        end
      end
      S_T1: begin
        state_next = S_IDLE;
        if (alu_cmd) begin
          sel_r      = 1'b1;
          sel_idx    = rx;
          a_wr       = 1'b1;
          state_next = S_T2;
        end else begin
          case (op)
            OP_MV:   begin sel_r = 1'b1; rx_wr = 1'b1; done = 1'b1; end
            OP_MVNZ: begin sel_r = 1'b1; rx_wr = (g_reg != '0); done = 1'b1; end
            OP_MVI:  begin sel_din = 1'b1; rx_wr = 1'b1; done = 1'b1; end
            OP_LD, OP_ST: begin
              sel_r      = 1'b1;
              addr_wr    = 1'b1;
              state_next = S_T2;
            end
            default: begin done = 1'b1; err = 1'b1; end
          endcase
        end
      end
      S_T2: begin
        state_next = S_IDLE;
        if (alu_cmd) begin
          sel_r      = 1'b1;
          g_wr       = 1'b1;
          state_next = S_T3;
        end else if (op == OP_LD) begin
          state_next = S_T3;
        end else if (op == OP_ST) begin
          sel_r   = 1'b1;
          sel_idx = rx;
          dout_wr = 1'b1;
          w       = 1'b1;
          done    = 1'b1;
        end
      end
      S_T3: begin
        // Only ALU ops and ld reach here: write back G or the memory read data.
        state_next = S_IDLE;
        rx_wr      = 1'b1;
        done       = 1'b1;
        if (alu_cmd) sel_g   = 1'b1;
        else         sel_din = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      ir_reg    <= '0;
      a_reg     <= '0;
      g_reg     <= '0;
      addr_reg  <= '0;
      dout_reg  <= '0;
      for (int i = 0; i < NREGS; i++) r_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_wr)   ir_reg       <= bus.DIN[IW-1:0];
      if (rx_wr)   r_reg[rx]    <= bus_val;
      if (a_wr)    a_reg        <= bus_val;
      if (g_wr)    g_reg        <= alu_y;
      if (addr_wr) addr_reg     <= bus_val;
      if (dout_wr) dout_reg     <= bus_val;
    end
  end

  assign bus.Done     = done;
  assign bus.Err      = err;
  assign bus.W        = w;
  assign bus.BusWires = bus_val;
  assign bus.ADDR     = addr_reg;
  assign bus.DOUT     = dout_reg;

endmodule
